// File: rtl/lz77_core_arbiter.sv
// Round-robin job arbiter that time-shares one LZ77 encoder core between two
// character streams: load a full string, run the core, forward its tuples, report.
module lz77_core_arbiter #(
  parameter int          STR_LEN  = 2048,
  parameter int          CNT_W    = 12,
  parameter int          TIMEOUT  = 65535,
  parameter logic [7:0]  PAD_CHAR = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [7:0]       src_data0,
  input  logic [7:0]       src_data1,
  input  logic             src_valid0,
  input  logic             src_valid1,
  output logic             src_ready0,
  output logic             src_ready1,
  output logic             enc_reset,
  output logic [7:0]       enc_chardata,
  input  logic             enc_valid,
  input  logic             enc_finish,
  input  logic [3:0]       enc_offset,
  input  logic [2:0]       enc_match_len,
  input  logic [7:0]       enc_char_nxt,
  output logic             out_valid,
  output logic             out_id,
  output logic [3:0]       out_offset,
  output logic [2:0]       out_match_len,
  output logic [7:0]       out_char_nxt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             done_err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic             gnt_id;
  logic             rr_ptr;
  logic             err;
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] tuple_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic             vld_p1;
  logic             id_p1;
  logic [3:0]       off_p1;
  logic [2:0]       len_p1;
  logic [7:0]       nxt_p1;

  logic             pick;
  logic             sel_valid;
  logic [7:0]       sel_data;
  logic             load_active;
  logic             run_active;
  logic             tuple_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // With both channels requesting, rr_ptr names the favoured channel
  assign pick        = (req == 2'b11) ? rr_ptr : req[1];
  assign sel_valid   = gnt_id ? src_valid1 : src_valid0;
  assign sel_data    = gnt_id ? src_data1  : src_data0;
  assign load_active = (state == S_LOAD);
  assign run_active  = (state == S_RUN);
  assign tuple_in    = run_active & enc_valid;

  assign src_ready0   = load_active & ~gnt_id;
  assign src_ready1   = load_active &  gnt_id;
  assign enc_chardata = load_active ? (sel_valid ? sel_data : PAD_CHAR) : 8'h00;

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign done_id  = done & gnt_id;
  assign done_err = done & err;
  assign done_cnt = done ? tuple_cnt : '0;

  assign out_valid     = vld_p1;
  assign out_id        = id_p1;
  assign out_offset    = off_p1;
  assign out_match_len = len_p1;
  assign out_char_nxt  = nxt_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      gnt_id    <= 1'b0;
      rr_ptr    <= 1'b0;
      err       <= 1'b0;
      load_cnt  <= '0;
      tuple_cnt <= '0;
      tmo_cnt   <= '0;
      enc_reset <= 1'b1;
      vld_p1    <= 1'b0;
      id_p1     <= 1'b0;
      off_p1    <= '0;
      len_p1    <= '0;
      nxt_p1    <= '0;
    end else begin
      // p1: core tuple captured one cycle after enc_valid
      vld_p1 <= tuple_in;
      if (tuple_in) begin
        id_p1     <= gnt_id;
        off_p1    <= enc_offset;
        len_p1    <= enc_match_len;
        nxt_p1    <= enc_char_nxt;
        tuple_cnt <= sat_inc(tuple_cnt);
      end

      case (state)
        S_IDLE: begin
          enc_reset <= 1'b1;
          if (|req) begin
            gnt_id    <= pick;
            state     <= S_LOAD;
            load_cnt  <= '0;
            tuple_cnt <= '0;
            err       <= 1'b0;
            enc_reset <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!sel_valid) err <= 1'b1;
          load_cnt <= load_cnt + CNT_W'(1);
          if (load_cnt == CNT_W'(STR_LEN - 1)) begin
            state   <= S_RUN;
            tmo_cnt <= '0;
          end
        end
        S_RUN: begin
          if (enc_finish) begin
            state <= S_DONE;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          enc_reset <= 1'b1;
          rr_ptr    <= ~gnt_id;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lz77_core_arbiter.md
Name: lz77_core_arbiter

Overview:
- Shares one LZ77_Encoder core between two character-stream requesters.
- Grants a whole job (one STR_LEN-character string) to one requester at a time, round-robin.
- Sequences the core: holds it in reset, streams exactly STR_LEN characters into it, forwards its encoded tuples tagged with the owner, then detects finish or timeout.
- Sits between the input DMA channels and the encoder core.

Parameters:
- STR_LEN, 2048: characters per job; must equal the core's string buffer depth.
- CNT_W, 12: width of the load counter and the tuple counter.
- TIMEOUT, 65535: maximum RUN cycles before the job is aborted.
- PAD_CHAR, 8'h00: character substituted when the granted source has no data.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-channel job request; sampled only in IDLE.
- src_data0, src_data1  in  8  channel character data.
- src_valid0, src_valid1  in  1  channel data valid.
- src_ready0, src_ready1  out  1  channel character accepted this cycle.
- enc_reset  out  1  core reset, active-high, registered.
- enc_chardata  out  8  character to the core.
- enc_valid  in  1  core tuple valid.
- enc_finish  in  1  core finished.
- enc_offset  in  4  core tuple offset.
- enc_match_len  in  3  core tuple match length.
- enc_char_nxt  in  8  core tuple next character.
- out_valid  out  1  forwarded tuple valid.
- out_id  out  1  owning channel of the tuple.
- out_offset  out  4  forwarded offset.
- out_match_len  out  3  forwarded match length.
- out_char_nxt  out  8  forwarded next character.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle job-complete pulse.
- done_id  out  1  channel of the completed job.
- done_err  out  1  job had a pad insertion or a timeout.
- done_cnt  out  CNT_W  number of tuples forwarded for the job.

Behaviour:
- Reset, taken on the clk edge while reset is high: state IDLE, rr_ptr=0, enc_reset=1, all other outputs 0, counters 0, err=0.
- Reset mid-job aborts immediately: no done pulse, core held in reset.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - enc_reset=1.
  - If req != 0, grant one channel: if both are requesting, grant the channel with rr_ptr priority (0 means ch0 first); otherwise grant the single requester.
  - Latch gnt_id, go to LOAD, clear load_cnt, tuple_cnt and err.
- LOAD:
  - Registered enc_reset=0 from the first LOAD cycle.
  - Lasts exactly STR_LEN cycles; the core cannot stall.
  - src_ready of the granted channel=1 for every LOAD cycle; the other channel's src_ready=0.
  - enc_chardata is combinational: granted src_data if its src_valid=1; else PAD_CHAR, and err is set (sticky for the job).
  - load_cnt increments each cycle; when load_cnt==STR_LEN-1, go to RUN and clear the timeout counter.
- RUN:
  - enc_chardata=0.
  - On enc_valid, the next cycle gives out_valid=1, out_id=gnt_id and out_* = registered enc_* fields (latency 1), and tuple_cnt increments.
  - If enc_finish=1, go to DONE.
  - Else if the timeout counter reaches TIMEOUT-1, set err and go to DONE.
  - enc_valid and enc_finish in the same cycle: the tuple is still forwarded and counted.
- DONE, one cycle:
  - done=1, done_id=gnt_id, done_err=err, done_cnt=tuple_cnt.
  - The tuple_cnt shown includes any tuple accepted in the final RUN cycle.
  - enc_reset is registered to 1; rr_ptr = ~gnt_id.
  - Go to IDLE; a new grant is possible on the following cycle.
- req changes outside IDLE are ignored; a requester that keeps req high after its own done is served again only when the other channel is idle or has been served.
- tuple_cnt saturates at all-ones; no wrap.
- enc_* inputs are ignored outside RUN.
- out_valid is never high in IDLE or LOAD.

Test Plan:
- Single job: req=2'b01, ch0 streams 'A','B','A','B',... with valid always high → src_ready0 high for exactly 2048 cycles, enc_reset low from the first LOAD cycle, each tuple appears on out_* one cycle after enc_valid with out_id=0, done with done_id=0, done_err=0, done_cnt equal to the number of enc_valid pulses.
- Contention: req=2'b11 from reset → ch0 granted first; after its done, ch1 granted on the next IDLE cycle; with req=2'b11 held, grants alternate 0,1,0,1.
- Source underrun: ch1 drops src_valid for 3 LOAD cycles → enc_chardata=8'h00 in exactly those cycles, load still ends after 2048 cycles, done_err=1.
- Timeout: TIMEOUT=100, core model never asserts enc_finish → done 100 RUN cycles after LOAD ends, done_err=1, enc_reset=1 the cycle after done.
- Reset mid-LOAD: assert reset at load_cnt=500 → next cycle state IDLE, enc_reset=1, busy=0, no done pulse; a subsequent req=2'b10 grants ch1 with load_cnt restarting at 0.
- Same-cycle finish: enc_valid and enc_finish high together → that tuple is forwarded, and done_cnt includes it.
